// File: rtl/rectangle_sbox_layer_ctrl_if.sv
// Bundle between the RECTANGLE SubColumn sequencer, its round controller and the external masked S-box.
// slave = sequencer side, master = controller/S-box side.
interface rectangle_sbox_layer_ctrl_if #(
    parameter int NUM_COL = 16,
    parameter int RAND_W  = 8
);
    localparam int SW = 4 * NUM_COL;

    logic              start;
    logic [SW-1:0]     in_share0;
    logic [SW-1:0]     in_share1;
    logic [RAND_W-1:0] rnd_in;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [3:0]        sbox_a0b0c0d0;
    logic [3:0]        sbox_a1b1c1d1;
    logic [RAND_W-1:0] sbox_ran;
    logic [3:0]        sbox_x0y0z0t0;
    logic [3:0]        sbox_x1y1z1t1;
    logic              busy;
    logic              done;
    logic [SW-1:0]     out_share0;
    logic [SW-1:0]     out_share1;

    modport slave (
        input  start, in_share0, in_share1, rnd_in, rnd_valid,
        input  sbox_x0y0z0t0, sbox_x1y1z1t1,
        output rnd_ready, sbox_a0b0c0d0, sbox_a1b1c1d1, sbox_ran,
        output busy, done, out_share0, out_share1
    );

    modport master (
        output start, in_share0, in_share1, rnd_in, rnd_valid,
        output sbox_x0y0z0t0, sbox_x1y1z1t1,
        input  rnd_ready, sbox_a0b0c0d0, sbox_a1b1c1d1, sbox_ran,
        input  busy, done, out_share0, out_share1
    );
endinterface

// File: rtl/rectangle_sbox_layer_ctrl.sv
// RECTANGLE SubColumn layer sequencer: streams 16 two-share columns through one external masked S-box.
// Optional RECTANGLE_CTRL_ZEROIZE_EN: clear state after DONE and gate out_share0/1 with done.
module rectangle_sbox_layer_ctrl #(
    parameter int NUM_COL  = 16,
    parameter int SBOX_LAT = 1,
    parameter int RAND_W   = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    rectangle_sbox_layer_ctrl_if.slave bus
);
    localparam int SW = 4 * NUM_COL;
    localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int IW = $clog2(SW);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]             iss_idx, cap_cnt, cap_idx;
    logic [SBOX_LAT:1]         vld_pipe;
    logic [SBOX_LAT:1][CW-1:0] idx_pipe;
    logic                      load, issue, cap, clr;

    assign load    = (state == IDLE) && bus.start;
    assign issue   = (state == FEED) && bus.rnd_valid;
    assign cap     = vld_pipe[SBOX_LAT];
    assign cap_idx = idx_pipe[SBOX_LAT];

`ifdef RECTANGLE_CTRL_ZEROIZE_EN
    assign clr = (state == DONE);
`else
    assign clr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iss_idx <= '0;
            cap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                iss_idx <= '0;
                cap_cnt <= '0;
            end else begin
                if (issue) iss_idx <= iss_idx + CW'(1);
                if (cap)   cap_cnt <= cap_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = FEED;
            FEED:  if (issue && iss_idx == CW'(NUM_COL - 1)) state_nxt = DRAIN;
            DRAIN: if (cap && cap_cnt == CW'(NUM_COL - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Column tags track the S-box pipeline so results land in the column they came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            idx_pipe[1] <= iss_idx;
            for (int i = 2; i <= SBOX_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    // Each share has its own register and datapath; nothing here ever mixes the two.
    for (genvar s = 0; s < 2; s++) begin : g_shr
        logic [SW-1:0] st;
        logic [SW-1:0] ld_val;
        logic [3:0]    res;
        logic [3:0]    col;

        if (s == 0) begin : g_s0
            assign ld_val = bus.in_share0;
            assign res    = bus.sbox_x0y0z0t0;
        end else begin : g_s1
            assign ld_val = bus.in_share1;
            assign res    = bus.sbox_x1y1z1t1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st <= '0;
            end else if (load) begin
                st <= ld_val;
            end else if (clr) begin
                st <= '0;
            end else if (cap) begin
                for (int r = 0; r < 4; r++)
                    st[IW'(r * NUM_COL) + IW'(cap_idx)] <= res[r];
            end
        end

        // Zeros outside issue cycles keep stale share data off the S-box inputs.
        always_comb begin
            col = '0;
            if (issue)
                for (int r = 0; r < 4; r++)
                    col[r] = st[IW'(r * NUM_COL) + IW'(iss_idx)];
        end
    end

    assign bus.sbox_a0b0c0d0 = g_shr[0].col;
    assign bus.sbox_a1b1c1d1 = g_shr[1].col;
    assign bus.sbox_ran      = issue ? bus.rnd_in : '0;
    assign bus.rnd_ready     = issue;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);

`ifdef RECTANGLE_CTRL_ZEROIZE_EN
    assign bus.out_share0 = bus.done ? g_shr[0].st : '0;
    assign bus.out_share1 = bus.done ? g_shr[1].st : '0;
`else
    assign bus.out_share0 = g_shr[0].st;
    assign bus.out_share1 = g_shr[1].st;
`endif
endmodule

// File: tb/tb_rectangle_sbox_layer_ctrl.sv
// Randomized scoreboard bench for rectangle_sbox_layer_ctrl with a behavioural masked S-box model.
module tb_rectangle_sbox_layer_ctrl;
    localparam int NUM_COL  = 16;
    localparam int SBOX_LAT = 1;
    localparam int RAND_W   = 8;
    localparam int LAT      = NUM_COL + SBOX_LAT + 1;
    localparam logic [63:0] ROWS_BC = 64'h0000FFFFFFFF0000;
    localparam logic [3:0] SB [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                       4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

    typedef struct {
        logic [63:0] in0;
        logic [63:0] in1;
        logic [63:0] exp;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    rectangle_sbox_layer_ctrl_if #(.NUM_COL(NUM_COL), .RAND_W(RAND_W)) bus ();

    rectangle_sbox_layer_ctrl #(.NUM_COL(NUM_COL), .SBOX_LAT(SBOX_LAT), .RAND_W(RAND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Masked S-box model: one-edge latency, output share 0 is a mask taken from the randomness.
    logic [3:0] sx0 = '0, sx1 = '0;
    always @(posedge clk) begin
        sx0 <= bus.sbox_ran[3:0] ^ bus.sbox_ran[7:4];
        sx1 <= SB[bus.sbox_a0b0c0d0 ^ bus.sbox_a1b1c1d1] ^ bus.sbox_ran[3:0] ^ bus.sbox_ran[7:4];
    end
    assign bus.sbox_x0y0z0t0 = sx0;
    assign bus.sbox_x1y1z1t1 = sx1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] col4(input logic [63:0] v, input int k);
        logic [63:0] t;
        t = v >> k;
        return {t[48], t[32], t[16], t[0]};
    endfunction

    // Unmasked reference: S applied to every column of (share0 ^ share1).
    function automatic logic [63:0] ref_layer(input logic [63:0] s0, input logic [63:0] s1);
        logic [63:0] r;
        logic [3:0]  y;
        r = '0;
        for (int k = 0; k < NUM_COL; k++) begin
            y = SB[col4(s0 ^ s1, k)];
            r = r | ({63'b0, y[0]} << k) | ({63'b0, y[1]} << (16 + k))
                  | ({63'b0, y[2]} << (32 + k)) | ({63'b0, y[3]} << (48 + k));
        end
        return r;
    endfunction

    // Monitor: checks S-box feed, stall zeroing, done timing and result.
    int          cols = 0;
    bit          post_done = 0;
    logic [63:0] last0, last1;
    exp_t        me;
    always @(negedge clk) begin
        if (!rst_n) begin
            cols = 0;
            post_done = 0;
        end else begin
            if (post_done) begin
`ifdef RECTANGLE_CTRL_ZEROIZE_EN
                chk("post_done_out0", bus.out_share0, 64'h0);
                chk("post_done_out1", bus.out_share1, 64'h0);
`else
                chk("post_done_out0", bus.out_share0, last0);
                chk("post_done_out1", bus.out_share1, last1);
`endif
                chk("post_done_busy", {63'b0, bus.busy}, 64'h0);
                post_done = 0;
            end
            chk("ready_without_valid", {63'b0, bus.rnd_ready & ~bus.rnd_valid}, 64'h0);
            if (bus.rnd_ready) begin
                if (q.size() == 0 || cyc <= q[0].start_cyc || cols >= NUM_COL) begin
                    chk("rnd_ready_outside_feed", {63'b0, bus.rnd_ready}, 64'h0);
                end else begin
                    chk("sbox_share0_col", {60'b0, bus.sbox_a0b0c0d0}, {60'b0, col4(q[0].in0, cols)});
                    chk("sbox_share1_col", {60'b0, bus.sbox_a1b1c1d1}, {60'b0, col4(q[0].in1, cols)});
                    chk("sbox_ran", {56'b0, bus.sbox_ran}, {56'b0, bus.rnd_in});
                    cols++;
                end
            end else begin
                chk("idle_sbox_zero", {48'b0, bus.sbox_a0b0c0d0, bus.sbox_a1b1c1d1, bus.sbox_ran}, 64'h0);
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {63'b0, bus.done}, 64'h0);
                end else begin
                    me = q.pop_front();
                    chk("layer_result", bus.out_share0 ^ bus.out_share1, me.exp);
                    chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
                    chk("columns_issued", 64'(cols), 64'(NUM_COL));
                    last0 = bus.out_share0;
                    last1 = bus.out_share1;
                    post_done = 1;
                end
                cols = 0;
            end
        end
    end

    // mode 0: rnd_valid always 1; 1: 3-cycle stall after column 5; 2: random stalls;
    // 3: no stalls plus stray start pulses at cycles 5 and 18. reset_at >= 0 pulls rst_n mid-layer.
    task automatic run_layer(input logic [63:0] in0, input logic [63:0] in1, input int mode,
                             input int reset_at);
        bit   pat[$];
        int   ones, zeros, stall_left, p, n;
        bit   v;
        exp_t e;
        ones = 0; zeros = 0; stall_left = 3;
        while (ones < NUM_COL) begin
            case (mode)
                1: v = !(ones == 6 && stall_left > 0);
                2: v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            if (!v && mode == 1) stall_left--;
            pat.push_back(v);
            if (v) ones++; else zeros++;
        end
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("idle_before_start", {63'b0, bus.busy}, 64'h0);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in_share0 = in0;
        bus.in_share1 = in1;
        bus.rnd_valid = 1'($urandom);
        bus.rnd_in = RAND_W'($urandom);
        p = cyc;
        e.in0 = in0; e.in1 = in1; e.exp = ref_layer(in0, in1);
        e.start_cyc = p; e.done_cyc = p + LAT + zeros;
        q.push_back(e);
        for (int j = 0; j < pat.size() + SBOX_LAT + 3; j++) begin
            @(posedge clk); #1;
            bus.start = (mode == 3 && (j == 4 || j == 17));
            bus.in_share0 = {$urandom, $urandom};
            bus.in_share1 = {$urandom, $urandom};
            bus.rnd_valid = (j < pat.size()) ? pat[j] : 1'($urandom);
            bus.rnd_in = RAND_W'($urandom);
            if (j == reset_at) begin
                rst_n = 1'b0;
                q.delete();
                #1;
                chk("reset_busy", {63'b0, bus.busy}, 64'h0);
                chk("reset_done", {63'b0, bus.done}, 64'h0);
                chk("reset_out0", bus.out_share0, 64'h0);
                chk("reset_out1", bus.out_share1, 64'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        bus.start = 1'b0;
        bus.in_share0 = '0;
        bus.in_share1 = '0;
        bus.rnd_valid = 1'b1;
        bus.rnd_in = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, bus.busy}, 64'h0);
        chk("rst_done", {63'b0, bus.done}, 64'h0);
        chk("rst_rnd_ready", {63'b0, bus.rnd_ready}, 64'h0);
        chk("rst_out0", bus.out_share0, 64'h0);
        chk("rst_out1", bus.out_share1, 64'h0);
        chk("rst_sbox_in", {48'b0, bus.sbox_a0b0c0d0, bus.sbox_a1b1c1d1, bus.sbox_ran}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_rnd_ready", {63'b0, bus.rnd_ready}, 64'h0);

        run_layer(64'h0, 64'h0, 0, -1);
        r = {$urandom, $urandom};
        run_layer(r, r ^ ROWS_BC, 1, -1);
        run_layer(r, r ^ ROWS_BC, 0, -1);
        for (int i = 0; i < 10; i++) begin
            r = {$urandom, $urandom};
            run_layer(r, r ^ ROWS_BC, 2, -1);
        end
        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 3, -1);
        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 0, 8);
        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 0, -1);
        for (int i = 0; i < 5; i++)
            run_layer({$urandom, $urandom}, {$urandom, $urandom}, 2, -1);

        repeat (30) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rectangle_sbox_layer_ctrl.md
Name: rectangle_sbox_layer_ctrl

Overview:
- Sequencer for the RECTANGLE SubColumn layer built on one first-order masked 4-bit S-box instance.
- Holds a two-share 64-bit masked state and feeds its 16 columns through the shared S-box, one per cycle.
- Supplies fresh randomness per column, captures the masked results back in place, and handshakes with the round controller.
- The S-box is instantiated outside this block; this block drives and samples its ports.

Parameters:
- NUM_COL, 16, number of columns (S-box applications) per layer.
- SBOX_LAT, 1, S-box latency in clock edges from input/randomness sample to valid output.
- RAND_W, 8, fresh random bits consumed per S-box call.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load in_share0/1 and begin a layer; ignored while busy
- in_share0  in  64  share 0 of state: [15:0]=row a, [31:16]=row b, [47:32]=row c, [63:48]=row d
- in_share1  in  64  share 1, same layout
- rnd_in  in  RAND_W  fresh randomness
- rnd_valid  in  1  rnd_in is valid this cycle
- rnd_ready  out  1  rnd_in consumed this cycle
- sbox_a0b0c0d0  out  4  share 0 column to S-box, {d,c,b,a}
- sbox_a1b1c1d1  out  4  share 1 column to S-box, {d,c,b,a}
- sbox_ran  out  RAND_W  randomness to S-box
- sbox_x0y0z0t0  in  4  S-box share 0 result, {t,z,y,x}
- sbox_x1y1z1t1  in  4  S-box share 1 result, {t,z,y,x}
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse: layer complete
- out_share0  out  64  result share 0; valid when done=1
- out_share1  out  64  result share 1; valid when done=1

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; state registers, issue/capture counters, pipeline tags, busy, done, out_share0/1 and rnd_ready all 0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE -> FEED: on start=1. Load both shares into separate state registers; issue index = 0.
- FEED, issue rule:
  - Column k is issued when rnd_valid=1.
  - In that cycle: sbox_a0b0c0d0 = {s0[48+k], s0[32+k], s0[16+k], s0[k]}; sbox_a1b1c1d1 likewise from share 1; sbox_ran = rnd_in; rnd_ready=1.
  - Tag {valid, k} enters a SBOX_LAT-deep shift register.
- FEED, stall (rnd_valid=0): sbox_a*/sbox_ran driven to 0, rnd_ready=0, no tag inserted; issue index holds.
- Capture: when a tag exits the shift register, write result nibble into column k of each share, x->row a, y->b, z->c, t->d. Issued columns are never overwritten before capture.
- FEED -> DRAIN: after column NUM_COL-1 is issued.
- DRAIN -> DONE: when the last tag is captured.
- DONE -> IDLE: after 1 cycle. In DONE: done=1, out_share0/1 = state. busy=1 in FEED, DRAIN and DONE.
- Latency with no stalls: done asserts NUM_COL+SBOX_LAT+1 cycles after the start edge (18 with defaults). Each stall cycle adds 1.
- Share separation: share 0 and share 1 are never combined in any logic. Non-issue cycles drive zeros so no stale share is re-presented to the S-box.
- Simultaneous events:
  - start in any state other than IDLE is ignored.
  - start in the DONE cycle is ignored; a new layer needs start in IDLE.
  - rnd_valid outside FEED: rnd_ready stays 0.
- Reset mid-operation: immediate return to IDLE, all state zero, no done pulse.

Optional Feature:
- Macro RECTANGLE_CTRL_ZEROIZE_EN.
- Defined: on the edge leaving DONE, both state registers are cleared to 0, and out_share0/1 read 0 whenever done=0.
- Undefined: state registers hold the last result until the next start, and out_share0/1 continuously reflect the state registers.

Test Plan:
- Reset, start with in_share0=0, in_share1=0, rnd_valid=1 constant -> done at cycle 18; out_share0^out_share1 = 0x0000FFFFFFFF0000 (S(0)=6 per column).
- in_share0 = random R, in_share1 = R ^ 0x0000FFFFFFFF0000 (unmasked all-6 columns, S(6)=7) -> out_share0^out_share1 = 0x0000FFFFFFFFFFFF; results identical across 10 random R and rnd_in streams.
- rnd_valid low for 3 cycles after column 5 -> done at cycle 21. During stalls, sbox_a*/sbox_ran = 0 and rnd_ready=0. Result matches the unstalled run.
- start pulsed again at cycles 5 and 18 (DONE) -> ignored; exactly one done pulse; busy low at cycle 19.
- rst_n asserted at cycle 9 -> busy, done, out_share* = 0 immediately; subsequent start completes normally in 18 cycles.
- With RECTANGLE_CTRL_ZEROIZE_EN: out_share0/1 = 0 the cycle after done, and internal state is 0. Without it: out_share0/1 retain the result.
